// File: rtl/bit8_1to2demux_buf.sv
// Byte-wide 1-to-2 demultiplexer with a small FIFO on each output lane.
// One input stream is steered by in_sel into lane 0 or lane 1. Each lane
// drains through its own port and counts the bytes it has accepted.
//
// Handshake: a transfer happens on a rising clk edge when valid && ready.
// Once valid is high, the producer holds data (and in_sel) stable until
// ready is seen. in_ready depends only on reset, in_sel and the selected
// lane's full flag. It never looks at a same-cycle pop, which keeps that
// path short. outk_valid and outk_data come from registered lane state only.

// One output lane: a circular FIFO plus an accepted-byte counter.
module bit8_1to2demux_buf_lane #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CNT_W-1:0] cnt
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COUNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [COUNT_W-1:0] count;
  logic               do_push;
  logic               do_pop;

  // Occupancy flags come straight from the registered count.
  assign valid = (count != '0);
  assign full  = (count == COUNT_FULL);

  // A full lane ignores a push even if the top offers one. An empty lane
  // ignores pop_ready, so nothing can underflow.
  assign do_push = push && !full;
  assign do_pop  = valid && pop_ready;

  // Head byte; forced to zero when empty so reset and drained lanes read 0.
  assign data = valid ? mem[rd_ptr] : '0;

  // Storage array. Contents are only observed through valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Write pointer. DEPTH is a power of two, so natural overflow wraps it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (do_push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer advances on every pop and wraps the same way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (do_pop) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy. A push and a pop on the same edge leave it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Accepted-byte counter. It wraps naturally and ignores pops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (do_push) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// Top level: steers the input stream into the two lanes.
module bit8_1to2demux_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic full0;
  logic full1;
  logic accept;
  logic push0;
  logic push1;

  // Ready follows only the selected lane. A full target stalls the whole
  // input, even if the other lane has room, so input order is never changed.
  assign in_ready = !reset && !(in_sel ? full1 : full0);
  assign accept   = in_valid && in_ready;
  assign push0    = accept && !in_sel;
  assign push1    = accept &&  in_sel;

  bit8_1to2demux_buf_lane #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_lane0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push0),
    .push_data (in_data),
    .pop_ready (out0_ready),
    .full      (full0),
    .data      (out0_data),
    .valid     (out0_valid),
    .cnt       (cnt0)
  );

  bit8_1to2demux_buf_lane #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_lane1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push1),
    .push_data (in_data),
    .pop_ready (out1_ready),
    .full      (full1),
    .data      (out1_data),
    .valid     (out1_valid),
    .cnt       (cnt1)
  );

endmodule
